// File: rtl/char_scanout.sv
// char_scanout: walks one character-buffer row per active line, fetches glyph rows from the
// char ROM and serialises them MSB-first. Define CHAR_SCANOUT_CURSOR_EN for a blinking cursor overlay.
module char_scanout #(
  parameter int COLS      = 80,
  parameter int ROWS      = 24,
  parameter int ADDR_BITS = 11,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic [4:0]           first_row,
  output logic [ADDR_BITS-1:0] raddr,
  input  logic [7:0]           rdata,
  output logic [10:0]          rom_addr,
  input  logic [7:0]           rom_data,
`ifdef CHAR_SCANOUT_CURSOR_EN
  input  logic [6:0]           cursor_col,
  input  logic [4:0]           cursor_row,
  input  logic                 cursor_on,
`endif
  output logic                 pixel,
  output logic                 pixel_valid,
  output logic                 busy
);
  localparam int SUB_W = $clog2(CHAR_W);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [SUB_W-1:0]       sub_q, sub_d, pix_left_q, pix_left_d;
  logic [COL_W-1:0]       col_q, col_d, fetch_col;
  logic                   stage1_q, stage1_d, stage2_q, stage2_d;
  logic                   last1_q, last1_d, last2_q, last2_d, last_cell_q, last_cell_d;
  logic                   inv_q, inv_d, pix_valid_q, pix_valid_d;
  logic [CHAR_W-1:0]      shreg_q, shreg_d, glyph;
  logic [3:0]             scan_q, scan_d;
  logic [4:0]             row_q, row_d, fs_row;
  logic [ADDR_BITS-1:0]   row_base_q, row_base_d, fs_base;
  logic                   issue, eol;
`ifdef CHAR_SCANOUT_CURSOR_EN
  logic [4:0]             scr_row_q, scr_row_d, frame_cnt_q, frame_cnt_d;
  logic                   cursor_hit;
`endif

  // Glyph row widened or truncated to the cell width; pad columns are blank.
  if (CHAR_W > 8) begin : g_wide
    assign glyph = {rom_data, {(CHAR_W - 8){1'b0}}};
  end else if (CHAR_W == 8) begin : g_exact
    assign glyph = rom_data;
  end else begin : g_narrow
    assign glyph = rom_data[7 -: CHAR_W];
  end

  assign busy        = (state_q != S_IDLE);
  assign pixel_valid = pix_valid_q;
  assign pixel       = pix_valid_q & shreg_q[CHAR_W-1];
  assign rom_addr    = stage1_q ? {rdata[6:0], scan_q} : 11'd0;

  always_comb begin
    fs_row      = (int'(first_row) < ROWS) ? first_row : 5'd0;
    fs_base     = ADDR_BITS'(int'(fs_row) * COLS);
    fetch_col   = line_start ? '0 : col_q;
    issue       = line_start || (state_q == S_FETCH && sub_q == '0);
    eol         = pix_valid_q && (pix_left_q == '0) && last_cell_q;
    raddr       = line_start ? (frame_start ? fs_base : row_base_q)
                             : row_base_q + ADDR_BITS'(col_q);

    state_d     = state_q;
    sub_d       = sub_q;
    col_d       = col_q;
    stage1_d    = issue;
    last1_d     = issue && (fetch_col == COL_W'(COLS - 1));
    stage2_d    = stage1_q;
    last2_d     = last1_q;
    inv_d       = inv_q;
    shreg_d     = shreg_q << 1;
    pix_left_d  = pix_left_q;
    pix_valid_d = pix_valid_q;
    last_cell_d = last_cell_q;
    scan_d      = scan_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
`ifdef CHAR_SCANOUT_CURSOR_EN
    scr_row_d   = scr_row_q;
    frame_cnt_d = frame_cnt_q;
    cursor_hit  = cursor_on && frame_cnt_q[4] && (int'(col_q) == int'(cursor_col))
                  && (scr_row_q == cursor_row);
`endif

    if (state_q == S_FETCH) begin
      if (sub_q == SUB_W'(CHAR_W - 1)) begin
        sub_d = '0;
        if (col_q == COL_W'(COLS - 1)) begin
          state_d = S_DRAIN;
          col_d   = '0;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end

    if (stage1_q) begin
`ifdef CHAR_SCANOUT_CURSOR_EN
      inv_d = rdata[7] ^ cursor_hit;
`else
      inv_d = rdata[7];
`endif
    end

    // Loads land exactly when the previous cell's last pixel is out, keeping the stream gapless.
    if (stage2_q) begin
      shreg_d     = glyph ^ {CHAR_W{inv_q}};
      pix_valid_d = 1'b1;
      pix_left_d  = SUB_W'(CHAR_W - 1);
      last_cell_d = last2_q;
    end else if (pix_valid_q) begin
      if (pix_left_q == '0) begin
        pix_valid_d = 1'b0;
        last_cell_d = 1'b0;
      end else begin
        pix_left_d = pix_left_q - SUB_W'(1);
      end
    end

    if (eol) begin
      state_d = S_IDLE;
    end

    // row_base advances by accumulation so no multiplier sits on the per-line path.
    if (eol && !line_start) begin
      if (scan_q == 4'(CHAR_H - 1)) begin
        scan_d = 4'd0;
`ifdef CHAR_SCANOUT_CURSOR_EN
        scr_row_d = (scr_row_q == 5'(ROWS - 1)) ? 5'd0 : scr_row_q + 5'd1;
`endif
        if (row_q == 5'(ROWS - 1)) begin
          row_d      = 5'd0;
          row_base_d = '0;
        end else begin
          row_d      = row_q + 5'd1;
          row_base_d = row_base_q + ADDR_BITS'(COLS);
        end
      end else begin
        scan_d = scan_q + 4'd1;
      end
    end

    if (frame_start) begin
      row_d       = fs_row;
      row_base_d  = fs_base;
      scan_d      = 4'd0;
`ifdef CHAR_SCANOUT_CURSOR_EN
      scr_row_d   = 5'd0;
      frame_cnt_d = frame_cnt_q + 5'd1;
`endif
      state_d     = S_IDLE;
      sub_d       = '0;
      col_d       = '0;
      stage1_d    = 1'b0;
      last1_d     = 1'b0;
      stage2_d    = 1'b0;
      last2_d     = 1'b0;
      pix_valid_d = 1'b0;
      pix_left_d  = '0;
      last_cell_d = 1'b0;
    end

    if (line_start) begin
      state_d     = S_FETCH;
      sub_d       = SUB_W'(1);
      col_d       = '0;
      stage1_d    = 1'b1;
      stage2_d    = 1'b0;
      last2_d     = 1'b0;
      pix_valid_d = 1'b0;
      pix_left_d  = '0;
      last_cell_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      col_q       <= '0;
      stage1_q    <= 1'b0;
      stage2_q    <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      last_cell_q <= 1'b0;
      inv_q       <= 1'b0;
      shreg_q     <= '0;
      pix_left_q  <= '0;
      pix_valid_q <= 1'b0;
      scan_q      <= 4'd0;
      row_q       <= 5'd0;
      row_base_q  <= '0;
`ifdef CHAR_SCANOUT_CURSOR_EN
      scr_row_q   <= 5'd0;
      frame_cnt_q <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      col_q       <= col_d;
      stage1_q    <= stage1_d;
      stage2_q    <= stage2_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      last_cell_q <= last_cell_d;
      inv_q       <= inv_d;
      shreg_q     <= shreg_d;
      pix_left_q  <= pix_left_d;
      pix_valid_q <= pix_valid_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
`ifdef CHAR_SCANOUT_CURSOR_EN
      scr_row_q   <= scr_row_d;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end
endmodule

// File: doc/char_scanout.md
Name: char_scanout

Overview:
- Read-side engine for the 1920x8 character buffer; converts buffer contents into a serial pixel stream for the video output.
- Per active line: walks the buffer row, looks up glyph rows in the external char ROM, and shifts out pixels MSB-first at one pixel per clk.
- Owns the hardware scroll offset (first_row), the row/scanline counters and the address wrap-around.

Parameters:
- COLS, 80, characters per row
- ROWS, 24, character rows per screen
- ADDR_BITS, 11, buffer address width
- CHAR_W, 8, pixels per character cell; minimum 3
- CHAR_H, 16, scanlines per character row; power of 2, at most 16

Ports:
- clk  in  1  pixel clock; single clock domain
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at top of frame
- line_start  in  1  one-cycle pulse at start of each active line
- first_row  in  5  buffer row shown at top of screen, 0..ROWS-1; sampled on frame_start
- raddr  out  ADDR_BITS  char buffer read address
- rdata  in  8  char buffer read data; valid 1 cycle after raddr
- rom_addr  out  11  {rdata[6:0], scanline[3:0]} to char ROM
- rom_data  in  8  glyph row; valid 1 cycle after rom_addr
- pixel  out  1  video pixel; 1 = lit
- pixel_valid  out  1  high during the COLS*CHAR_W active pixels of a line
- busy  out  1  high from line_start until the last pixel has been emitted

Behaviour:
- Reset: raddr=0, rom_addr=0, pixel=0, pixel_valid=0, busy=0, row=0, scanline=0, row_base=0, col=0.
- frame_start: row<=first_row; row_base<=first_row*COLS; scanline<=0. Values of first_row >= ROWS clamp to 0.
- Fetch sequence for line_start at cycle T:
  - Fetch for column k issues raddr=row_base+k at cycle T+k*CHAR_W.
  - rom_addr is driven at T+k*CHAR_W+1 using that cycle's rdata[6:0] and the current scanline.
  - Shift register loads rom_data at T+k*CHAR_W+2.
- Pixels of column k appear at cycles T+3+k*CHAR_W .. T+3+k*CHAR_W+CHAR_W-1, MSB (bit 7) first.
  - When CHAR_W>8, pad bits are 0.
  - When CHAR_W<8, only the top CHAR_W bits are shown.
- Pixel latency is 3 cycles; the stream is gapless across characters.
- Inverse video: if rdata[7]=1 for a character, all CHAR_W pixels of that cell are inverted, including pad bits.
- pixel=0 whenever pixel_valid=0.
- busy rises at T+1 and falls after the last pixel, at cycle T+3+COLS*CHAR_W.
- End of line:
  - scanline increments.
  - When scanline wraps from CHAR_H-1 to 0, row and row_base advance.
  - row==ROWS-1 wraps to 0, and row_base wraps from (ROWS-1)*COLS to 0. No multiplier; row_base is an accumulator.
- Address range: raddr never reaches ROWS*COLS or beyond.
- line_start while busy: abort the current line without advancing scanline, and restart fetch at col 0 of the same scanline.
- frame_start and line_start in the same cycle: frame_start takes effect first, and the line fetch uses the new row_base with scanline 0.
- frame_start while busy: abort the line; pixel_valid drops the next cycle.
- Line pulses with no preceding frame_start: counters run from their reset values.
- Asynchronous reset mid-line: all outputs drop to their reset values immediately.

Optional Feature:
- Macro: CHAR_SCANOUT_CURSOR_EN.
- When defined, the block adds these inputs:
  - cursor_col[6:0]
  - cursor_row[4:0], screen-relative, i.e. before first_row offset
  - cursor_on (1 bit)
- A free-running frame counter counts frame_start pulses. Blink phase = counter bit 4, toggling every 16 frames.
- When the displayed cell matches the cursor and cursor_on=1 with blink phase 1, every pixel of that cell is inverted. This XOR applies after inverse video.
- Without the macro: no cursor ports, no frame counter, and no cursor logic.

Test Plan:
- Scroll wrap: reset, first_row=0, frame_start, then line_start -> raddr steps 0,1,..,79 at 8-cycle spacing; first pixel at T+3; pixel_valid high for 640 cycles; busy falls at T+643.
- Glyph path: rdata=0x41 and rom_data=0xA5 for every cell -> rom_addr=0x410 on scanline 0; pixel pattern 1,0,1,0,0,1,0,1 repeats 80 times.
- Inverse video: rdata=0xC1 with rom_data=0xA5 -> pattern 0,1,0,1,1,0,1,0.
- Row wrap: first_row=23, frame_start, then 16 lines -> raddr base 1840; on the 17th line raddr base is 0.
- Abort: line_start, then a second line_start 100 cycles later -> raddr restarts at row_base; scanline unchanged; pixel_valid continuous from T2+3 for 640 cycles.
- Simultaneous pulses and reset: frame_start and line_start together with first_row=5 -> first raddr=400, scanline 0; reset_n low mid-line -> pixel, pixel_valid and busy are 0 in the same cycle.
